// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch stage feeding instr_decode.
// Holds the fetch PC, issues word requests to instruction memory, presents
// fetched words with their PC under a valid/stall handshake, and parks one
// response in a skid register when decode is stalled. Redirects retarget the
// PC and flush in-flight work; an outstanding request is drained in S_DROP.
// Optional feature: FETCH_MISALIGN_TRAP_EN adds a `misaligned` output and
// halts fetching after a redirect to a non-word-aligned target.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_SKID = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic        halt_q, halt_next;

  logic        ack_v;
  logic        out_free;
  logic [31:0] fetch_pc_inc;
  logic [31:0] redirect_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign halt_q     = mis_q;
  assign misaligned = mis_q;
`else
  assign halt_q = 1'b0;
`endif

  // An ack only means something while a request is actually on the bus.
  assign ack_v        = imem_ack && req_q;
  assign out_free     = !valid_q || !stall;
  assign fetch_pc_inc = fetch_pc_q + 32'd4;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Next-state logic: redirect first, then per-state fetch/skid/drop behaviour.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    halt_next    = halt_q;

    if (redirect_valid) begin
      fetch_pc_d   = redirect_tgt;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_next = (redirect_pc[1:0] != 2'b00);
      if (halt_next) begin
        pc_d = redirect_pc;
      end
`endif
      if (req_q && !imem_ack) begin
        // Memory still owes us a response for the old address: keep it asked.
        state_d = S_DROP;
        req_d   = 1'b1;
        addr_d  = addr_q;
      end else begin
        state_d = S_REQ;
        req_d   = !halt_next;
        addr_d  = redirect_tgt;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (out_free) begin
            valid_d = 1'b0;
          end
          if (ack_v) begin
            fetch_pc_d = fetch_pc_inc;
            addr_d     = fetch_pc_inc;
            if (out_free) begin
              instr_d = imem_rdata;
              pc_d    = addr_q;
              valid_d = 1'b1;
              req_d   = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = addr_q;
              skid_valid_d = 1'b1;
              state_d      = S_SKID;
              req_d        = 1'b0;
            end
          end else begin
            req_d = !halt_q;
          end
        end
        S_SKID: begin
          req_d = 1'b0;
          if (out_free) begin
            instr_d      = skid_instr_q;
            pc_d         = skid_pc_q;
            valid_d      = skid_valid_q;
            skid_valid_d = 1'b0;
            state_d      = S_REQ;
            req_d        = !halt_q;
            addr_d       = fetch_pc_q;
          end
        end
        S_DROP: begin
          if (out_free) begin
            valid_d = 1'b0;
          end
          if (ack_v) begin
            state_d = S_REQ;
            req_d   = !halt_q;
            addr_d  = fetch_pc_q;
          end
        end
        default: begin
          state_d = S_REQ;
          req_d   = 1'b0;
        end
      endcase
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d = halt_next;
`endif
  end

  // State, fetch PC, memory request, output and skid registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      instr_q      <= '0;
      pc_q         <= '0;
      valid_q      <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q        <= mis_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios followed by a randomized run.
// Memory returns addr + 32'h13 after a configurable number of wait states;
// a program-order scoreboard checks every instruction decode consumes.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .instr         (instr),
    .pc            (pc),
    .instr_valid   (instr_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misaligned    (misaligned)
`endif
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // memory model: wait_mode 0..2 fixed wait states, 3 = random 0..2
  int unsigned wait_mode = 0;
  bit          rand_stray = 1'b0;
  bit          mem_busy = 1'b0;
  int unsigned mem_cnt = 0;

  // reference model: next PC decode must receive in program order
  logic [31:0] exp_pc = '0;
  int unsigned n_consumed = 0;

  // cross-cycle expectations
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_instr = '0;
  bit          prev_redir = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic clear_model();
    prev_pend  = 1'b0;
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
    mem_busy   = 1'b0;
    exp_pc     = 32'h0000_0000;
  endtask

  // Assert reset mid-operation, hold it two cycles, then release.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk1("rst_req_async", imem_req, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk1("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk1("rst_valid", instr_valid, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk1("rst_misaligned", misaligned, 1'b0);
`endif
    end
    reset = 1'b1;
    clear_model();
  endtask

  // One cycle: check carried expectations, model memory, drive inputs, score.
  task automatic step(input logic st, input logic rv, input logic [31:0] rp);
    logic ack;
    @(negedge clk);
    if (prev_pend) begin
      chk1("req_held", imem_req, 1'b1);
      chk("addr_held", imem_addr, prev_addr);
    end
    if (prev_hold) begin
      chk1("hold_valid", instr_valid, 1'b1);
      chk("hold_pc", pc, prev_pc);
      chk("hold_instr", instr, prev_instr);
    end
    if (prev_redir) chk1("redir_flush", instr_valid, 1'b0);
    if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);

    ack = 1'b0;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = (wait_mode == 3) ? $urandom_range(0, 2) : wait_mode;
      end
      if (mem_cnt == 0) begin
        ack = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else begin
      mem_busy = 1'b0;
      ack = rand_stray && ($urandom_range(0, 3) == 0);
    end
    imem_ack       = ack;
    imem_rdata     = (ack && imem_req) ? imem_addr + 32'h13 : $urandom;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;

    if (instr_valid && !st && !rv) begin
      chk("seq_pc", pc, exp_pc);
      chk("seq_instr", instr, exp_pc + 32'h13);
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    if (rv) exp_pc = rp & 32'hFFFF_FFFC;

    prev_pend  = imem_req && !ack;
    prev_addr  = imem_addr;
    prev_hold  = instr_valid && st && !rv;
    prev_pc    = pc;
    prev_instr = instr;
    prev_redir = rv;
  endtask

  initial begin
    int unsigned base;
    logic        st;
    logic        rv;
    logic [31:0] rp;

    #1 reset = 1'b0;

    // reset values and first request
    wait_mode = 0;
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);

    // zero-wait streaming: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk1("zw_valid", instr_valid, 1'b1);
      chk("zw_pc", pc, 32'(i * 4));
    end

    // reset mid-request, then stall while @4 is valid and @8 returns
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("st_pc0", pc, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("st_pc4", pc, 32'h4);
    chk("st_ack_addr", imem_addr, 32'h8);
    chk1("st_ack_req", imem_req, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("st_hold_pc", pc, 32'h4);
      chk1("st_skid_noreq", imem_req, 1'b0);
    end
    step(1'b0, 1'b0, 32'h0);
    chk("st_release_pc", pc, 32'h4);
    chk1("st_release_noreq", imem_req, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk("st_skid_pc", pc, 32'h8);
    chk("st_skid_instr", instr, 32'h1B);
    chk1("st_skid_valid", instr_valid, 1'b1);
    chk1("st_resume_req", imem_req, 1'b1);
    chk("st_resume_addr", imem_addr, 32'hC);
    step(1'b0, 1'b0, 32'h0);
    chk("st_next_pc", pc, 32'hC);

    // two wait states, redirect in the first wait cycle
    do_reset();
    wait_mode = 2;
    step(1'b0, 1'b1, 32'h200);
    chk1("dr_req", imem_req, 1'b1);
    chk("dr_addr0", imem_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("dr_addr1", imem_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("dr_addr2", imem_addr, 32'h0);
    chk1("dr_ack", imem_ack, 1'b1);
    step(1'b0, 1'b0, 32'h0);
    chk("dr_new_addr", imem_addr, 32'h200);
    chk1("dr_no_valid", instr_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk1("dr_valid", instr_valid, 1'b1);
    chk("dr_pc", pc, 32'h200);

    // 32-bit wrap of the fetch PC
    wait_mode = 0;
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    base = n_consumed;
    for (int i = 0; i < 20 && (n_consumed - base) < 3; i++) step(1'b0, 1'b0, 32'h0);
    chk1("wrap_progress", (n_consumed - base) >= 3, 1'b1);

    // misaligned redirect target
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0102);
    step(1'b0, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("mis_flag", misaligned, 1'b1);
    chk1("mis_noreq", imem_req, 1'b0);
    chk("mis_pc", pc, 32'h0000_0102);
    chk1("mis_novalid", instr_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk1("mis_still_noreq", imem_req, 1'b0);
    step(1'b0, 1'b1, 32'h300);
    step(1'b0, 1'b0, 32'h0);
    chk1("mis_cleared", misaligned, 1'b0);
    chk1("mis_resume_req", imem_req, 1'b1);
    chk("mis_resume_addr", imem_addr, 32'h300);
    step(1'b0, 1'b0, 32'h0);
    chk("mis_resume_pc", pc, 32'h300);
`else
    chk1("mis_req", imem_req, 1'b1);
    chk("mis_addr", imem_addr, 32'h100);
    chk1("mis_novalid", instr_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk1("mis_valid", instr_valid, 1'b1);
    chk("mis_pc", pc, 32'h100);
`endif

    // randomized run against the scoreboard
    do_reset();
    wait_mode  = 3;
    rand_stray = 1'b1;
    base = n_consumed;
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
      else rp = $urandom_range(0, 1023) << 2;
      step(st, rv, rp);
    end
    chk1("rand_progress", (n_consumed - base) > 100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
